// File: rtl/dircc_timer_pkg.sv
// Shared constants for the node interval-timer: register map, control words and FSM state codes.
package dircc_timer_pkg;

  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;

  // START | CONT | ITO, and STOP
  localparam logic [15:0] CTRL_RUN  = 16'h0007;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef logic [2:0] tick_state_t;

  localparam tick_state_t ST_WR_PL    = 3'd0;
  localparam tick_state_t ST_WR_PH    = 3'd1;
  localparam tick_state_t ST_WR_CTRL  = 3'd2;
  localparam tick_state_t ST_IDLE     = 3'd3;
  localparam tick_state_t ST_ACK      = 3'd4;
  localparam tick_state_t ST_ACK_WAIT = 3'd5;
  localparam tick_state_t ST_WR_STOP  = 3'd6;
  localparam tick_state_t ST_DISABLED = 3'd7;

endpackage

// File: rtl/dircc_node_tick_scheduler_if.sv
// Write-only Avalon-MM link between the tick scheduler (master) and the interval timer s1 (slave).
interface dircc_node_tick_scheduler_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata
  );

  modport slave (
    input avm_address,
    input avm_chipselect,
    input avm_write_n,
    input avm_writedata
  );
endinterface

// File: rtl/dircc_tick_pend_counter.sv
// Saturating pending-tick counter; optional sticky overrun and lost-tick count under TICK_OVERRUN_DETECT_EN.
module dircc_tick_pend_counter #(
  parameter int PEND_W = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic pend_valid,
  output logic overrun
);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              full;
  logic              lost;

  assign full       = &pend_q;
  assign pend_valid = (pend_q != '0);
  // a simultaneous accept frees a slot, so only an unmatched increment at full is lost
  assign lost       = inc & ~dec & full;

  always_comb begin
    pend_d = pend_q;
    if (inc && !dec && !full) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (dec && !inc && pend_valid) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

`ifdef TICK_OVERRUN_DETECT_EN
  logic        overrun_q, overrun_d;
  logic [15:0] lost_q, lost_d;

  always_comb begin
    overrun_d = overrun_q | lost;
    lost_d    = lost_q;
    if (lost && lost_q != 16'hFFFF) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
      lost_q    <= '0;
    end else begin
      overrun_q <= overrun_d;
      lost_q    <= lost_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: rtl/dircc_node_tick_scheduler.sv
// Programs the node interval timer, acknowledges its timeouts and streams ticks to the core.
// Optional sticky overrun detection is built when TICK_OVERRUN_DETECT_EN is defined.
module dircc_node_tick_scheduler
  import dircc_timer_pkg::*;
#(
  parameter logic [31:0] INIT_PERIOD = 32'd49999,
  parameter int          PEND_W      = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  dircc_node_tick_scheduler_if.master      avm,
  input  logic                             timer_irq,
  input  logic                             cfg_enable,
  input  logic [31:0]                      cfg_period,
  input  logic                             cfg_load,
  output logic                             tick_valid,
  input  logic                             tick_ready,
  output logic [31:0]                      tick_count,
  output logic                             busy,
  output logic                             overrun
);

  tick_state_t state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        reload_q, reload_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [2:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [15:0] wd_q, wd_d;
  logic        ack;

  // Avalon outputs are registered, so each write shows on the bus the cycle after its state
  always_comb begin
    state_d = state_q;
    addr_d  = TMR_STATUS;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    wd_d    = 16'h0000;
    case (state_q)
      ST_WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_PERIOD_L; wd_d = period_q[15:0];
        state_d = ST_WR_PH;
      end
      ST_WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_PERIOD_H; wd_d = period_q[31:16];
        state_d = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_CONTROL;
        wd_d    = cfg_enable ? CTRL_RUN : CTRL_STOP;
        state_d = cfg_enable ? ST_IDLE : ST_DISABLED;
      end
      ST_IDLE: begin
        if (timer_irq)       state_d = ST_ACK;
        else if (reload_q)   state_d = ST_WR_PL;
        else if (!cfg_enable) state_d = ST_WR_STOP;
      end
      ST_ACK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_STATUS; wd_d = 16'h0000;
        state_d = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: state_d = ST_IDLE;
      ST_WR_STOP: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_CONTROL; wd_d = CTRL_STOP;
        state_d = ST_DISABLED;
      end
      ST_DISABLED: begin
        if (timer_irq)      state_d = ST_ACK;
        else if (cfg_enable) state_d = ST_WR_CTRL;
        else if (reload_q)  state_d = ST_WR_PL;
      end
      default: state_d = ST_WR_PL;
    endcase
  end

  assign ack = (state_q == ST_ACK);

  always_comb begin
    period_d     = cfg_load ? cfg_period : period_q;
    reload_d     = reload_q | cfg_load;
    // a load landing on the WR_PL entry edge is already in period_q for this write sequence
    if (state_d == ST_WR_PL && state_q != ST_WR_PL) begin
      reload_d = 1'b0;
    end
    tick_count_d = tick_count_q;
    if (ack) begin
      tick_count_d = tick_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_WR_PL;
      period_q     <= INIT_PERIOD;
      reload_q     <= 1'b0;
      tick_count_q <= '0;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      reload_q     <= reload_d;
      tick_count_q <= tick_count_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      wd_q         <= wd_d;
    end
  end

  dircc_tick_pend_counter #(
    .PEND_W (PEND_W)
  ) u_pend (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc        (ack),
    .dec        (tick_valid & tick_ready),
    .pend_valid (tick_valid),
    .overrun    (overrun)
  );

  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wn_q;
  assign avm.avm_writedata  = wd_q;
  assign tick_count         = tick_count_q;
  assign busy               = (state_q != ST_IDLE) && (state_q != ST_DISABLED);

endmodule

// File: tb/tb_dircc_node_tick_scheduler.sv
// Directed self-checking bench for dircc_node_tick_scheduler.
module tb_dircc_node_tick_scheduler;

  logic        clk;
  logic        reset_n;
  logic        timer_irq;
  logic        cfg_enable;
  logic [31:0] cfg_period;
  logic        cfg_load;
  logic        tick_valid;
  logic        tick_ready;
  logic [31:0] tick_count;
  logic        busy;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  dircc_node_tick_scheduler_if avm_if ();

  dircc_node_tick_scheduler #(
    .INIT_PERIOD (32'd49999),
    .PEND_W      (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .avm        (avm_if),
    .timer_irq  (timer_irq),
    .cfg_enable (cfg_enable),
    .cfg_period (cfg_period),
    .cfg_load   (cfg_load),
    .tick_valid (tick_valid),
    .tick_ready (tick_ready),
    .tick_count (tick_count),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TICK_OVERRUN_DETECT_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] addr, input logic [15:0] data);
    chk({tag, "_cs"},   32'(avm_if.avm_chipselect), 32'd1);
    chk({tag, "_wn"},   32'(avm_if.avm_write_n),    32'd0);
    chk({tag, "_addr"}, 32'(avm_if.avm_address),    32'(addr));
    chk({tag, "_data"}, 32'(avm_if.avm_writedata),  32'(data));
  endtask

  task automatic chk_nowr(input string tag);
    chk({tag, "_cs"}, 32'(avm_if.avm_chipselect), 32'd0);
    chk({tag, "_wn"}, 32'(avm_if.avm_write_n),    32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    timer_irq  = 1'b0;
    cfg_enable = 1'b1;
    cfg_period = 32'd0;
    cfg_load   = 1'b0;
    tick_ready = 1'b0;
    repeat (3) step();

    chk_nowr("rst");
    chk("rst_addr",  32'(avm_if.avm_address),   32'd0);
    chk("rst_wd",    32'(avm_if.avm_writedata), 32'd0);
    chk("rst_busy",  32'(busy),       32'd1);
    chk("rst_valid", 32'(tick_valid), 32'd0);
    chk("rst_count", tick_count,      32'd0);
    chk("rst_ovr",   32'(overrun),    32'd0);

    // init sequence
    reset_n = 1'b1;
    step(); chk_wr("init_pl", 3'd2, 16'hC34F);
    step(); chk_wr("init_ph", 3'd3, 16'h0000);
    step(); chk_wr("init_ctrl", 3'd1, 16'h0007);
    chk("init_busy", 32'(busy), 32'd0);
    step(); chk_nowr("init_idle");
    chk("idle_busy", 32'(busy), 32'd0);

    // single irq pulse
    timer_irq = 1'b1;
    step(); timer_irq = 1'b0;
    chk_nowr("ack_pre");
    chk("ack_busy", 32'(busy), 32'd1);
    step(); chk_wr("ack1", 3'd0, 16'h0000);
    chk("ack1_count", tick_count, 32'd1);
    chk("ack1_valid", 32'(tick_valid), 32'd1);
    step(); chk_nowr("ack1_wait");
    tick_ready = 1'b1;
    step(); tick_ready = 1'b0;
    chk("drain1_valid", 32'(tick_valid), 32'd0);
    chk("drain1_count", tick_count, 32'd1);

    // stale irq held through ACK and ACK_WAIT
    timer_irq = 1'b1;
    step();
    step(); chk_wr("stale_ack", 3'd0, 16'h0000);
    step(); timer_irq = 1'b0;
    chk_nowr("stale_wait");
    step(); chk_nowr("stale_idle1");
    step(); chk_nowr("stale_idle2");
    chk("stale_count", tick_count, 32'd2);
    tick_ready = 1'b1;
    step(); tick_ready = 1'b0;
    chk("drain2_valid", 32'(tick_valid), 32'd0);

    // reload requested while in ACK
    timer_irq = 1'b1;
    step(); timer_irq = 1'b0;
    cfg_period = 32'h0001_86A0;
    cfg_load   = 1'b1;
    step(); cfg_load = 1'b0;
    chk_wr("rl_ack", 3'd0, 16'h0000);
    chk("rl_count", tick_count, 32'd3);
    step(); chk_nowr("rl_wait");
    step(); chk_nowr("rl_idle");
    step(); chk_wr("rl_pl", 3'd2, 16'h86A0);
    step(); chk_wr("rl_ph", 3'd3, 16'h0001);
    step(); chk_wr("rl_ctrl", 3'd1, 16'h0007);
    step(); chk_nowr("rl_done");
    chk("rl_busy", 32'(busy), 32'd0);
    tick_ready = 1'b1;
    step(); tick_ready = 1'b0;
    chk("drain3_valid", 32'(tick_valid), 32'd0);

    // disable / re-enable
    cfg_enable = 1'b0;
    step(); chk("stop_busy", 32'(busy), 32'd1);
    step(); chk_wr("stop", 3'd1, 16'h0008);
    chk("dis_busy", 32'(busy), 32'd0);
    step(); chk_nowr("dis_idle");
    chk("dis_busy2", 32'(busy), 32'd0);
    cfg_enable = 1'b1;
    step(); chk("en_busy", 32'(busy), 32'd1);
    step(); chk_wr("en_ctrl", 3'd1, 16'h0007);
    chk("en_busy2", 32'(busy), 32'd0);

    // saturation: 16 ticks with the core stalled
    for (int i = 0; i < 15; i++) begin
      timer_irq = 1'b1;
      step(); timer_irq = 1'b0;
      step(); step();
    end
    chk("sat15_count", tick_count, 32'd18);
    chk("sat15_ovr", 32'(overrun), 32'd0);
    timer_irq = 1'b1;
    step(); timer_irq = 1'b0;
    step(); step();
    chk("sat16_count", tick_count, 32'd19);
    chk("sat16_valid", 32'(tick_valid), 32'd1);
    chk("sat16_ovr", 32'(overrun), 32'(EXP_OVR));
    tick_ready = 1'b1;
    repeat (14) step();
    chk("sat_drain14_valid", 32'(tick_valid), 32'd1);
    step(); tick_ready = 1'b0;
    chk("sat_drain15_valid", 32'(tick_valid), 32'd0);
    chk("sat_ovr_sticky", 32'(overrun), 32'(EXP_OVR));

    // reset mid reload restarts with INIT_PERIOD
    cfg_period = 32'h1234_5678;
    cfg_load   = 1'b1;
    step(); cfg_load = 1'b0;
    step();
    reset_n = 1'b0;
    step(); chk_nowr("mid_rst");
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_count", tick_count, 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    step(); chk_wr("mid_pl", 3'd2, 16'hC34F);
    step(); chk_wr("mid_ph", 3'd3, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
